// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle CPU controller.
// The MULTICYCLE_ILLEGAL_TRAP_EN build routes illegal opcodes to HALT.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    WB_R      = 4'd7,
    EXEC_I    = 4'd8,
    WB_I      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    JAL       = 4'd12,
    JR        = 4'd13,
    HALT      = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
  localparam logic [1:0] MEMTOREG_PC     = 2'd2;

  localparam logic [1:0] SRCB_REGB  = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  function automatic logic legal_opcode(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_XORI, OP_LW, OP_SW: legal_opcode = 1'b1;
      default:                        legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_alu_decode.sv
// Combinational ALU command select from (state, opcode, funct).
// Shared with the ALU testbench; ADD unless the state needs otherwise.
module multicycle_alu_decode
  import multicycle_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output aluop_t     aluop
);

  always_comb begin
    aluop = ALU_ADD;
    case (state)
      EXEC_R: begin
        case (funct)
          F_SUB:   aluop = ALU_SUB;
          F_SLT:   aluop = ALU_SLT;
          F_AND:   aluop = ALU_AND;
          F_OR:    aluop = ALU_OR;
          F_XOR:   aluop = ALU_XOR;
          F_NOR:   aluop = ALU_NOR;
          default: aluop = ALU_ADD;
        endcase
      end
      EXEC_I:  aluop = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      BRANCH:  aluop = ALU_SUB;
      default: aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU sequencing controller: Moore-decoded datapath controls.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to halt on illegal opcodes (else NOP).
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic [1:0] PCSrc,
  output logic [3:0] state,
  output logic       instr_done
);

  localparam logic [3:0] CNT_RELOAD = 4'(MEM_LATENCY - 1);

  state_t     cur, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mem_last;
  aluop_t     alu_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
      cnt <= CNT_RELOAD;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  assign mem_last = (cnt == '0);
  assign state    = cur;

  multicycle_alu_decode u_alu_decode (
    .state  (cur),
    .opcode (opcode),
    .funct  (funct),
    .aluop  (alu_cmd)
  );

  always_comb begin
    nxt     = FETCH;
    cnt_nxt = cnt;
    case (cur)
      FETCH: nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     nxt = MEM_ADDR;
          OP_RTYPE:         nxt = (funct == F_JR) ? JR : EXEC_R;
          OP_ADDI, OP_XORI: nxt = EXEC_I;
          OP_BEQ, OP_BNE:   nxt = BRANCH;
          OP_J:             nxt = JUMP;
          OP_JAL:           nxt = JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:          nxt = HALT;
`else
          default:          nxt = FETCH;
`endif
        endcase
      end
      MEM_ADDR: nxt = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      // Both memory states share one down-counter, reloaded on exit.
      MEM_READ, MEM_WRITE: begin
        if (mem_last) begin
          nxt     = (cur == MEM_READ) ? MEM_WB : FETCH;
          cnt_nxt = CNT_RELOAD;
        end else begin
          nxt     = cur;
          cnt_nxt = cnt - 4'd1;
        end
      end
      EXEC_R: nxt = WB_R;
      EXEC_I: nxt = WB_I;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      HALT:   nxt = HALT;
`endif
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    MemToReg    = MEMTOREG_ALUOUT;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUop       = ALU_ADD;
    PCSrc       = PCSRC_ALU;
    instr_done  = 1'b0;
    if (!reset) begin
      ALUop = alu_cmd;
      case (cur)
        FETCH: begin
          IRWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        DECODE: begin
          ALUSrcB    = SRCB_IMMSH;
          instr_done = !legal_opcode(opcode);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          instr_done = 1'b0;
`endif
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEM_READ: IorD = 1'b1;
        MEM_WRITE: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_last;
        end
        MEM_WB: begin
          MemToReg   = MEMTOREG_MDR;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_R: ALUSrcA = 1'b1;
        WB_R: begin
          RegDst     = REGDST_RD;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        WB_I: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        // Only the PC-load qualifier looks at zero combinationally.
        BRANCH: begin
          ALUSrcA     = 1'b1;
          PCSrc       = PCSRC_ALUOUT;
          PCWriteCond = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCSrc      = PCSRC_JUMP;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        JAL: begin
          PCSrc      = PCSRC_JUMP;
          PCWrite    = 1'b1;
          RegDst     = REGDST_RA;
          MemToReg   = MEMTOREG_PC;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        JR: begin
          PCSrc      = PCSRC_REGA;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction expected control sequences built
// from instruction class, compared every cycle against the controller.
module tb_multicycle_control_fsm;

  localparam int unsigned LAT = 3;

  localparam int K_MEM = 0, K_R = 1, K_JR = 2, K_I = 3, K_BR = 4,
                 K_J = 5, K_JAL = 6, K_ILL = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemToReg, ALUSrcB, PCSrc;
  logic       ALUSrcA, instr_done;
  logic [2:0] ALUop;
  logic [3:0] state;

  multicycle_control_fsm #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSrc(PCSrc), .state(state),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, memw, irw, regw;
    logic [1:0] regdst, memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       done;
  } obs_t;

  obs_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic obs_t idle(input logic [3:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state; o.pcw = PCWrite; o.pcwc = PCWriteCond; o.iord = IorD;
    o.memw = MemWrite; o.irw = IRWrite; o.regw = RegWrite; o.regdst = RegDst;
    o.memtoreg = MemToReg; o.srca = ALUSrcA; o.srcb = ALUSrcB; o.aluop = ALUop;
    o.pcsrc = PCSrc; o.done = instr_done;
    return o;
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23, 6'h2B: return K_MEM;
      6'h00:        return (fn == 6'h08) ? K_JR : K_R;
      6'h08, 6'h0E: return K_I;
      6'h04, 6'h05: return K_BR;
      6'h02:        return K_J;
      6'h03:        return K_JAL;
      default:      return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'd1;
      6'h2A:   return 3'd3;
      6'h24:   return 3'd4;
      6'h25:   return 3'd7;
      6'h26:   return 3'd2;
      6'h27:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Expected per-cycle controls for one instruction, FETCH through last state.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_t o;
    int   k = kind_of(op, fn);
    q.delete();
    o = idle(4'd0); o.pcw = 1; o.irw = 1; o.srcb = 2'd1; q.push_back(o);
    o = idle(4'd1); o.srcb = 2'd3;
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    if (k == K_ILL) o.done = 1;
`endif
    q.push_back(o);
    case (k)
      K_MEM: begin
        o = idle(4'd2); o.srca = 1; o.srcb = 2'd2; q.push_back(o);
        for (int unsigned i = 0; i < LAT; i++) begin
          if (op == 6'h2B) begin
            o = idle(4'd5); o.iord = 1; o.memw = 1; o.done = (i == LAT - 1);
          end else begin
            o = idle(4'd3); o.iord = 1;
          end
          q.push_back(o);
        end
        if (op == 6'h23) begin
          o = idle(4'd4); o.memtoreg = 2'd1; o.regw = 1; o.done = 1; q.push_back(o);
        end
      end
      K_R: begin
        o = idle(4'd6); o.srca = 1; o.aluop = r_alu(fn); q.push_back(o);
        o = idle(4'd7); o.regdst = 2'd1; o.regw = 1; o.done = 1; q.push_back(o);
      end
      K_I: begin
        o = idle(4'd8); o.srca = 1; o.srcb = 2'd2; o.aluop = (op == 6'h0E) ? 3'd2 : 3'd0;
        q.push_back(o);
        o = idle(4'd9); o.regw = 1; o.done = 1; q.push_back(o);
      end
      K_BR: begin
        o = idle(4'd10); o.srca = 1; o.aluop = 3'd1; o.pcsrc = 2'd1; o.done = 1;
        o.pcwc = (op == 6'h04) ? z : !z;
        q.push_back(o);
      end
      K_J: begin
        o = idle(4'd11); o.pcsrc = 2'd2; o.pcw = 1; o.done = 1; q.push_back(o);
      end
      K_JAL: begin
        o = idle(4'd12); o.pcsrc = 2'd2; o.pcw = 1; o.regdst = 2'd2;
        o.memtoreg = 2'd2; o.regw = 1; o.done = 1; q.push_back(o);
      end
      K_JR: begin
        o = idle(4'd13); o.pcsrc = 2'd3; o.pcw = 1; o.done = 1; q.push_back(o);
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input obs_t exp);
    obs_t got = sample();
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (state %0d vs %0d)",
             tag, got, exp, got.st, exp.st);
    end
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 in next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input string tag);
    opcode = op; funct = fn; zero = z;
    build(op, fn, z);
    foreach (q[i]) begin
      @(negedge clk);
      check($sformatf("%s/step%0d", tag, i), q[i]);
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] legal_ops[11] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
                                6'h05, 6'h08, 6'h0E, 6'h23, 6'h2B};
  logic [5:0] r_functs[8]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h08};

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", idle(4'd0));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'h00, 6'h2A, 1'b0, "slt");
    run_instr(6'h23, 6'h11, 1'b0, "lw");
    run_instr(6'h2B, 6'h00, 1'b1, "sw");
    run_instr(6'h04, 6'h00, 1'b1, "beq_z1");
    run_instr(6'h05, 6'h00, 1'b1, "bne_z1");
    run_instr(6'h04, 6'h00, 1'b0, "beq_z0");
    run_instr(6'h05, 6'h00, 1'b0, "bne_z0");
    run_instr(6'h03, 6'h00, 1'b0, "jal");
    run_instr(6'h00, 6'h08, 1'b0, "jr");
    run_instr(6'h08, 6'h3F, 1'b0, "addi");
    run_instr(6'h0E, 6'h00, 1'b0, "xori");
    run_instr(6'h02, 6'h00, 1'b0, "j");
    run_instr(6'h00, 6'h3F, 1'b0, "r_unlisted");
    foreach (r_functs[i]) run_instr(6'h00, r_functs[i], 1'b0, "r_funct");

    // Reset held two cycles while in EXEC_R: no write may leak out.
    opcode = 6'h00; funct = 6'h2A; zero = 1'b0;
    build(6'h00, 6'h2A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("pre_rst/step%0d", i), q[i]);
      if (i < 2) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_1", idle(4'd0));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_2", idle(4'd0));
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(6'h00, 6'h20, 1'b0, "post_rst_add");

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = legal_ops[$urandom_range(0, 10)];
      fn = 6'($urandom);
      if (op == 6'h00 && $urandom_range(0, 1) == 1) fn = r_functs[$urandom_range(0, 7)];
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (kind_of(op, 6'h00) != K_ILL);
      end
`endif
      run_instr(op, fn, 1'($urandom), "rand");
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    opcode = 6'h3F; funct = '0; zero = 1'b0;
    build(6'h3F, 6'h00, 1'b0);
    foreach (q[i]) begin
      @(negedge clk);
      check($sformatf("ill/step%0d", i), q[i]);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom);
      @(negedge clk);
      check("halt_hold", idle(4'd14));
      @(posedge clk); #1;
    end
`else
    run_instr(6'h3F, 6'h00, 1'b0, "ill_nop");
    run_instr(6'h00, 6'h22, 1'b0, "after_ill");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main sequencing controller for the multicycle CPU. It decodes opcode/funct from the instruction register and steps each instruction through the fetch/decode/execute/memory/writeback states. Each cycle it drives the datapath enables, the mux selects and the 3-bit ALU command that feeds the ALU result multiplexer. One instance sits between the IR and the shared ALU/register-file/memory datapath.

Parameters:
MEM_LATENCY, 1, cycles spent in each memory-access state (MEM_READ, MEM_WRITE); legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, valid in BRANCH state
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  conditional PC load: BEQ when zero=1, BNE when zero=0
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register load
RegWrite  output  1  register file write
RegDst  output  2  write register select: 0=rt, 1=rd, 2=$31
MemToReg  output  2  write data select: 0=ALUOut, 1=MDR, 2=PC
ALUSrcA  output  1  0=PC, 1=regA
ALUSrcB  output  2  0=regB, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2
ALUop  output  3  ALU command: 0=ADD, 1=SUB, 2=XOR, 3=SLT, 4=AND, 5=NAND, 6=NOR, 7=OR
PCSrc  output  2  PC source: 0=ALU, 1=ALUOut, 2=jump target, 3=regA
state  output  4  current state code, for debug
instr_done  output  1  one-cycle pulse in the last state of each instruction

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high `reset`. Reset loads state=FETCH and the wait counter with MEM_LATENCY-1. Reset mid-instruction abandons the instruction with no further writes.
- Output style: all outputs are Moore-decoded from state, except PCWriteCond gating, which uses zero combinationally.
- Default output values: 0, ALUop=ADD. These are also the values held during reset.
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11, JAL=12, JR=13, HALT=14.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUop=ADD, PCSrc=0, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUop=ADD (branch target into ALUOut). Next state by opcode:
  - 0x23 (LW) or 0x2B (SW) -> MEM_ADDR
  - 0x00 (R-type) with funct 0x08 (JR) -> JR
  - 0x00 with any other funct -> EXEC_R
  - 0x08 (ADDI) or 0x0E (XORI) -> EXEC_I
  - 0x04 (BEQ) or 0x05 (BNE) -> BRANCH
  - 0x02 (J) -> JUMP
  - 0x03 (JAL) -> JAL
  - anything else -> illegal handling (see Optional Feature)
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUop=ADD. Next state MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ / MEM_WRITE:
  - IorD=1; MemWrite=1 in every MEM_WRITE cycle.
  - Stay MEM_LATENCY cycles, counting the counter down to 0.
  - Exit MEM_READ -> MEM_WB; exit MEM_WRITE -> FETCH with instr_done=1 in its last cycle.
  - Counter reloads to MEM_LATENCY-1 on exit.
- MEM_WB: RegDst=0, MemToReg=1, RegWrite=1, instr_done=1. Next state FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0. ALUop from funct: 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR; unlisted funct uses ADD. Next state WB_R.
- WB_R: RegDst=1, MemToReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUop=ADD for ADDI, XOR for XORI. Next state WB_I.
- WB_I: RegDst=0, MemToReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUop=SUB, PCSrc=1, PCWriteCond=1, instr_done=1. PC loads if (BEQ and zero) or (BNE and not zero). Next state FETCH.
- JUMP: PCSrc=2, PCWrite=1, instr_done=1. Next state FETCH.
- JAL: PCSrc=2, PCWrite=1, RegDst=2, MemToReg=2, RegWrite=1 in the same cycle. The old PC (already PC+4) is written to $31. instr_done=1. Next state FETCH.
- JR: PCSrc=3, PCWrite=1, instr_done=1. Next state FETCH.
- Opcode/funct are sampled in DECODE and in EXEC_R/EXEC_I/BRANCH/MEM_ADDR; the IR stays stable because IRWrite is asserted only in FETCH.
- Unused state codes 15: next state FETCH, all outputs at default values.

Optional Feature:
MULTICYCLE_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE -> HALT. HALT drives all enables 0 and stays in HALT until reset; state=14.
- Undefined: an illegal opcode is treated as a NOP. DECODE -> FETCH with instr_done=1 in DECODE. The HALT state is not generated.

Decomposition:
- Shared package multicycle_pkg holds:
  - state enum/localparams
  - ALUop codes (ADD..OR)
  - opcode and funct constants
  - mux-select encodings (RegDst, MemToReg, ALUSrcB, PCSrc)
- One natural sub-module: multicycle_alu_decode, a combinational map from (state, opcode, funct) to ALUop. It is reused by the ALU testbench.

Test Plan:
- reset=1 for 2 cycles mid-EXEC_R -> state=0, PCWrite=1, IRWrite=1, ALUop=0 in the first cycle after reset.
- opcode=0x00, funct=0x2A (SLT) -> states 0,1,6,7; ALUop=3 in EXEC_R; RegWrite=1, RegDst=1 and instr_done=1 in WB_R; 4 cycles total.
- LW (0x23) with MEM_LATENCY=3 -> 0,1,2,3,3,3,4; MemToReg=1, RegWrite=1 in MEM_WB; 7 cycles. SW (0x2B) -> 3 MemWrite cycles, then FETCH.
- BEQ (0x04) with zero=1 -> PCWriteCond=1 and PC load in BRANCH. BNE (0x05) with zero=1 -> no PC load; both take 3 cycles.
- JAL (0x03) -> state 12 with PCWrite=1, RegWrite=1, RegDst=2, MemToReg=2. JR (0x00, funct 0x08) -> state 13 with PCSrc=3.
- opcode=0x3F -> with MULTICYCLE_ILLEGAL_TRAP_EN: state=14 held for 20 cycles with no enables. Without it: back to FETCH after DECODE.
